// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group limits,
// the control part of a stage record, and the parameter legality check.
package cla_pkg;

  localparam int GROUP_MAX = 8;

  // Control bits carried by every pipeline stage alongside its data slices.
  typedef struct packed {
    logic valid;
    logic carry;
    logic c_msb;
  } stage_ctl_t;

  function automatic bit params_ok(input int width, input int group);
    return (group >= 1) && (group <= GROUP_MAX) && (width >= group) &&
           ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every internal carry is a
// flat sum-of-products of generate/propagate terms and the group carry-in.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             term;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci, built term by term.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & ci);
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign co    = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group per stage,
// a registered output, and a single global advance enable for backpressure.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / GROUP;

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  if (!params_ok(WIDTH, GROUP)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, GROUP in 1..%0d",
           GROUP_MAX);
  end

  // Valid/ready: a transfer happens on a cycle where valid and ready are both
  // high; the whole pipeline advances together whenever the output slot is
  // free or being drained, so ready never depends on in_valid.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  stage_t           st  [STAGES];
  stage_t           nxt [STAGES];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign b_eff    = B ^ {WIDTH{Sub}};
  assign c0       = Cin ^ Sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] psum_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [GROUP-1:0] s;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] psum;

    if (k == 0) begin : g_first
      assign v_in    = in_valid;
      assign c_in    = c0;
      assign psum_in = '0;
      assign a_in    = A;
      assign b_in    = b_eff;
    end else begin : g_rest
      assign v_in    = st[k-1].ctl.valid;
      assign c_in    = st[k-1].ctl.carry;
      assign psum_in = st[k-1].psum;
      assign a_in    = st[k-1].a_rem;
      assign b_in    = st[k-1].b_rem;
    end

    // Operand slices are shifted down each stage so the next group is always
    // at the bottom of the remaining-operand fields.
    cla_group #(.GROUP(GROUP)) u_group (
      .a    (a_in[GROUP-1:0]),
      .b    (b_in[GROUP-1:0]),
      .ci   (c_in),
      .s    (s),
      .co   (co),
      .c_msb(c_msb)
    );

    always_comb begin
      psum                     = psum_in;
      psum[k*GROUP +: GROUP]   = s;
    end

    assign nxt[k] = '{ctl:   '{valid: v_in, carry: co, c_msb: c_msb},
                      psum:  psum,
                      a_rem: a_in >> GROUP,
                      b_rem: b_in >> GROUP};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st[k] <= nxt[k];
      end
    end
  end

  // Output slot: holds data and flags unchanged for as long as it is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= st[STAGES-1].ctl.valid;
      Sum       <= st[STAGES-1].psum;
      Cout      <= st[STAGES-1].ctl.carry;
      Ovf       <= st[STAGES-1].ctl.c_msb ^ st[STAGES-1].ctl.carry;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner sums, random streaming with
// bubbles, backpressure and mid-stream reset, scored against an arithmetic model.
module tb_pipelined_cla_adder;

  localparam int W      = 16;
  localparam int G      = 4;
  localparam int STAGES = W / G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic [3:0]   a4 = '0;
  logic [3:0]   b4 = '0;
  logic         cin4 = 1'b0;
  logic         sub4 = 1'b0;
  logic         out_valid4;
  logic         out_ready4 = 1'b1;
  logic [3:0]   sum4;
  logic         cout4;
  logic         ovf4;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic         lat_chk = 1'b1;
  logic         seen_front = 1'b0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4), .Ovf(ovf4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: plain unsigned and signed integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] ye;
    longint       us;
    longint       ss;
    longint       smax;
    logic [W:0]   ures;
    logic         o;
    ye   = sb ? ~y : y;
    us   = longint'(x) + longint'(ye) + longint'(ci ^ sb);
    ss   = longint'($signed(x)) + longint'($signed(ye)) + longint'(ci ^ sb);
    smax = (longint'(1) << (W - 1)) - 1;
    o    = (ss > smax) || (ss < -(smax + 1));
    ures = us[W:0];
    return {ures[W], o, ures[W-1:0]};
  endfunction

  // driver: call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      input logic sb, input logic use_given, input logic [W+1:0] given);
    int waited;
    logic ok;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      exp_q.push_back(use_given ? given : model(x, y, ci, sb));
      acc_q.push_back(cyc);
    end else begin
      check("accept_timeout", 64'(waited), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {45'b0, out_valid, cout, ovf, sum}, 64'(0));
        end else begin
          check("result", {46'b0, cout, ovf, sum}, 64'(exp_q[0]));
          if (lat_chk && !seen_front)
            check("latency", 64'(cyc - acc_q[0]), 64'(STAGES + 1));
          seen_front = 1'b1;
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen_front = 1'b0;
          end else begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
          end
        end
      end else if (lat_chk && exp_q.size() != 0 && cyc > acc_q[0] + STAGES + 1) begin
        check("late_out", 64'(cyc - acc_q[0]), 64'(STAGES + 1));
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        seen_front = 1'b0;
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_flags", {62'b0, cout, ovf}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // 4-bit single-stage instance: 1110 + 1110 + 1
    a4 = 4'b1110; b4 = 4'b1110; cin4 = 1'b1; sub4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    check("w4_in_ready", 64'(in_ready4), 64'(1));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("w4_valid_early", 64'(out_valid4), 64'(0));
    @(posedge clk); #1;
    check("w4_valid", 64'(out_valid4), 64'(1));
    check("w4_result", {58'b0, cout4, ovf4, sum4}, {58'b0, 1'b1, 1'b0, 4'b1101});
    idle(1);
    check("w4_valid_drop", 64'(out_valid4), 64'(0));

    // directed 16-bit corners with fixed expectations {Cout, Ovf, Sum}
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h8000});
    drain();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    drain();

    // back-to-back random stream
    for (int i = 0; i < 20; i++) send_rand();
    drain();

    // bubbles: alternating valid with out_ready held high
    for (int i = 0; i < 10; i++) begin
      send_rand();
      idle(1);
    end
    drain();

    // backpressure: 3-cycle out_ready drop mid-stream
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // random valid gaps and random out_ready
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send_rand();
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int i = 0; i < 50; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // reset with a stalled result and three more operations in flight
    out_ready = 1'b0;
    send(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_sum", 64'(sum), 64'(0));
    exp_q.delete();
    acc_q.delete();
    seen_front = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    send(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b0, '0);
    drain();
    idle(STAGES + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
